// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Holds the arbiter state encoding, default sizing and a clog2 helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 15;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set req bit at or after ptr.
// Produces the one-hot pick, its index, and whether any request is present.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = clog2(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic [ID_W-1:0]  pick_id,
    output logic             any
);

    logic found;
    int   idx;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        idx     = 0;
        any     = |req;
        // Walk the requesters in rotation order starting from ptr.
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter with registered one-hot grant and a turnaround cycle.
// Optional forced revoke of contended long holders when ARB_TIMEOUT_EN is defined.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ID_W     = clog2(N_REQ),
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    if (ID_W != clog2(N_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(N_REQ)");
    end
    if (MAX_HOLD >= (1 << HOLD_W)) begin : g_bad_hold
        $error("MAX_HOLD must fit in HOLD_W bits");
    end

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] pick;
    logic [ID_W-1:0]  pick_id;
    logic             any;
    logic             owner_req;
    logic             revoke;
    logic [ID_W-1:0]  next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (any)
    );

    assign owner_req = |(req & gnt);
    assign next_ptr  = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
    // Counts owned cycles including the current one, so revoke lands after MAX_HOLD cycles.
    logic [HOLD_W-1:0] hold_cnt;
    logic              others;
    assign others = |(req & ~gnt);
    assign revoke = (hold_cnt == HOLD_W'(MAX_HOLD)) && others;
`else
    assign revoke = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (any) begin
                        gnt       <= pick;
                        gnt_id    <= pick_id;
                        gnt_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= OWNED;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= HOLD_W'(1);
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                OWNED: begin
                    // A forced revoke retires the owner exactly like a voluntary release.
                    if (!owner_req || revoke) begin
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= next_ptr;
                        state     <= TURN;
                        timeout   <= revoke && owner_req;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter: a rule-level model predicts every post-edge output.
// Directed scenarios followed by sticky random requests with one-hot and starvation checks.
module tb_rr_bus_arbiter;

    localparam int N        = 4;
    localparam int ID_W     = 2;
    localparam int HOLD_W   = 4;
    localparam int MAX_HOLD = 15;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]    gnt;
        logic            gnt_valid;
        logic [ID_W-1:0] gnt_id;
        logic            busy;
        logic            timeout;
    } obs_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic            busy;
    logic            timeout;

    int   total;
    int   bad;
    obs_t expq[$];

    // Model of the arbitration rules: owner index (-1 none), rotation pointer, hold length.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_turn;
    bit m_to;

    bit random_phase;
    int wait_cnt[N];
    int run_len;
    int longest;
    logic [N-1:0] prev_gnt;

    rr_bus_arbiter #(
        .N_REQ    (N),
        .ID_W     (ID_W),
        .HOLD_W   (HOLD_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pickFrom(input logic [N-1:0] rq, input int base);
        for (int k = 0; k < N; k++) begin
            if (rq[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    task automatic modelStep(input logic r, input logic [N-1:0] rq, output obs_t e);
        bit released;
        bit contended;
        bit forced;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_turn = 0; m_to = 0;
        end else if (m_owner >= 0) begin
            released  = !rq[m_owner];
            contended = (rq & ~(N'(1) << m_owner)) != '0;
            forced    = TIMEOUT_ON && contended && (m_held == MAX_HOLD);
            if (released || forced) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_turn  = 1;
                m_to    = forced && !released;
            end else begin
                if (m_held < (1 << HOLD_W) - 1) m_held++;
                m_to = 0;
            end
        end else begin
            m_owner = pickFrom(rq, m_ptr);
            m_held  = 1;
            m_turn  = 0;
            m_to    = 0;
        end
        e.gnt       = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.gnt_valid = (m_owner >= 0);
        e.gnt_id    = (m_owner >= 0) ? ID_W'(m_owner) : '0;
        e.busy      = (m_owner >= 0) || m_turn;
        e.timeout   = m_to;
    endtask

    // Drive one cycle of inputs, predict the outputs after the coming edge, then step past it.
    task automatic applyStimulus(input logic r, input logic [N-1:0] rq);
        obs_t e;
        reset = r;
        req   = rq;
        modelStep(r, rq, e);
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input obs_t e);
        obs_t a;
        a.gnt = gnt; a.gnt_valid = gnt_valid; a.gnt_id = gnt_id;
        a.busy = busy; a.timeout = timeout;
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL scoreboard t=%0t got gnt=%b v=%b id=%0d busy=%b to=%b want gnt=%b v=%b id=%0d busy=%b to=%b",
                     $time, a.gnt, a.gnt_valid, a.gnt_id, a.busy, a.timeout,
                     e.gnt, e.gnt_valid, e.gnt_id, e.busy, e.timeout);
        end
        total++;
        if (!$onehot0(gnt)) begin
            bad++;
            $display("[TB] FAIL onehot t=%0t got gnt=%b want at most one bit", $time, gnt);
        end
    endtask

    // Monitor: pops one prediction per edge and tracks waiting time during the random phase.
    initial begin
        obs_t e;
        int bound;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput(e);
            end
            if (random_phase) begin
                if (gnt_valid && gnt == prev_gnt) run_len++;
                else if (gnt_valid) run_len = 1;
                else run_len = 0;
                if (run_len > longest) longest = run_len;
                prev_gnt = gnt;
                bound = (N - 1) * (longest + 2);
                for (int i = 0; i < N; i++) begin
                    if (req[i] && !gnt[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    total++;
                    if (wait_cnt[i] > bound) begin
                        bad++;
                        $display("[TB] FAIL starve req%0d t=%0t got wait=%0d want <= %0d",
                                 i, $time, wait_cnt[i], bound);
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] cur;
        total = 0; bad = 0; random_phase = 0;
        run_len = 0; longest = 0; prev_gnt = '0;
        m_owner = -1; m_ptr = 0; m_held = 0; m_turn = 0; m_to = 0;
        foreach (wait_cnt[i]) wait_cnt[i] = 0;

        $display("[TB] reset then single request");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0001);
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0000);

        $display("[TB] rotation with all requesting");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b1111);
        for (int g = 0; g < 5; g++) begin
            repeat (3) applyStimulus(1'b0, 4'b1111);
            applyStimulus(1'b0, 4'b1111 & ~(4'b0001 << (g % N)));
            applyStimulus(1'b0, 4'b1111);
        end

        $display("[TB] long holder then release");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0100);
        repeat (30) applyStimulus(1'b0, 4'b1110);
        applyStimulus(1'b0, 4'b1010);
        repeat (3) applyStimulus(1'b0, 4'b1010);

        $display("[TB] reset mid grant");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0010);
        applyStimulus(1'b0, 4'b0010);
        applyStimulus(1'b1, 4'b0010);
        applyStimulus(1'b0, 4'b0010);
        applyStimulus(1'b0, 4'b0010);

`ifdef ARB_TIMEOUT_EN
        $display("[TB] forced revoke and uncontended hold");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0001);
        repeat (20) applyStimulus(1'b0, 4'b0011);
        applyStimulus(1'b1, 4'b0000);
        repeat (25) applyStimulus(1'b0, 4'b0001);
`endif

        $display("[TB] random requests");
        applyStimulus(1'b1, 4'b0000);
        cur = '0;
        random_phase = 1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5) == 0) cur[i] = ~cur[i];
            end
            applyStimulus(1'b0, cur);
        end
        random_phase = 0;

        #3;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain got %0d pending want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
